pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : forwarding, load-use stall, redirect flush and interrupt
//                    entry sequencing for a 5-stage in-order pipeline
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [31:0]      id_pc,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regWrite,
  input  logic             ex_memRead2,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_regWrite,
  input  logic             wb_regWrite,
  input  logic             ex_redirect,
  input  logic             intr_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             trap_sel,
  output logic             int_take,
  output logic [31:0]      epc,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] C_DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    INT_DRAIN = 2'd1,
    INT_ENTER = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [31:0]      epc_q, epc_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             load_use;
  logic             unused_ex_regwrite;

  assign unused_ex_regwrite = ex_regWrite;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!RST) begin
      if (mem_regWrite && mem_rd != 5'd0 && mem_rd == ex_rs1)     fwd_a = 2'b01;
      else if (wb_regWrite && wb_rd != 5'd0 && wb_rd == ex_rs1)   fwd_a = 2'b10;
      if (mem_regWrite && mem_rd != 5'd0 && mem_rd == ex_rs2)     fwd_b = 2'b01;
      else if (wb_regWrite && wb_rd != 5'd0 && wb_rd == ex_rs2)   fwd_b = 2'b10;
    end
  end

  assign load_use = ex_memRead2 && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    epc_d       = epc_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    trap_sel    = 1'b0;
    int_take    = 1'b0;
    if (RST) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (intr_req) begin
            // The trigger cycle is the first of the DRAIN_CYCLES bubbles.
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            epc_d       = id_pc;
            cnt_d       = C_DRAIN_LOAD;
            state_d     = (DRAIN_CYCLES > 1) ? INT_DRAIN : INT_ENTER;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        INT_DRAIN: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - DW'(1);
          if (cnt_q <= DW'(1)) state_d = INT_ENTER;
        end
        INT_ENTER: begin
          int_take    = 1'b1;
          trap_sel    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (id_ex_flush && bubble_q != '1) bubble_d = bubble_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      epc_q    <= '0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      bubble_q <= bubble_d;
    end
  end

  assign epc        = epc_q;
  assign bubble_cnt = bubble_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl : directed self-checking bench for pipe_hazard_ctrl
// Revision: 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_regWrite, ex_memRead2;
  logic        mem_regWrite, wb_regWrite, ex_redirect, intr_req;
  logic [31:0] id_pc;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, trap_sel, int_take;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] epc;
  logic [15:0] bubble_cnt;

  int total = 0;
  int bad   = 0;
  int exp_bub = 0;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_pc(id_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regWrite(ex_regWrite), .ex_memRead2(ex_memRead2),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regWrite(mem_regWrite), .wb_regWrite(wb_regWrite),
    .ex_redirect(ex_redirect), .intr_req(intr_req),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .trap_sel(trap_sel),
    .int_take(int_take), .epc(epc), .bubble_cnt(bubble_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_pc = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regWrite = 0; ex_memRead2 = 0;
    mem_rd = 0; wb_rd = 0; mem_regWrite = 0; wb_regWrite = 0;
    ex_redirect = 0; intr_req = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1;
    ex_rs1 = 5; mem_rd = 5; mem_regWrite = 1;
    repeat (2) @(negedge CLK);
    #1;
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL rst_pc_write: got %b expected 1", pc_write); end
    total++; if (if_id_write !== 1'b1) begin bad++; $display("FAIL rst_if_id_write: got %b expected 1", if_id_write); end
    total++; if (if_id_flush !== 1'b1) begin bad++; $display("FAIL rst_if_id_flush: got %b expected 1", if_id_flush); end
    total++; if (id_ex_flush !== 1'b1) begin bad++; $display("FAIL rst_id_ex_flush: got %b expected 1", id_ex_flush); end
    total++; if (trap_sel !== 1'b0 || int_take !== 1'b0) begin bad++; $display("FAIL rst_trap: got trap_sel=%b int_take=%b expected 0 0", trap_sel, int_take); end
    total++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin bad++; $display("FAIL rst_fwd: got %b/%b expected 00/00", fwd_a, fwd_b); end
    total++; if (epc !== 32'h0 || bubble_cnt !== 16'h0) begin bad++; $display("FAIL rst_regs: got epc=%h bub=%h expected 0 0", epc, bubble_cnt); end
    clear_inputs();
    RST = 0;
    exp_bub = 0;
  endtask

  task automatic test_forwarding();
    @(negedge CLK);
    ex_rs1 = 5; mem_rd = 5; mem_regWrite = 1; wb_rd = 5; wb_regWrite = 1;
    #1;
    total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL fwd_mem_prio: got %b expected 01", fwd_a); end
    @(negedge CLK);
    mem_rd = 0; wb_rd = 0;
    #1;
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL fwd_x0: got %b expected 00", fwd_a); end
    @(negedge CLK);
    clear_inputs();
    ex_rs1 = 5; ex_rs2 = 9; wb_rd = 9; wb_regWrite = 1; mem_rd = 9; mem_regWrite = 0;
    #1;
    total++; if (fwd_b !== 2'b10 || fwd_a !== 2'b00) begin bad++; $display("FAIL fwd_wb_b: got a=%b b=%b expected 00 10", fwd_a, fwd_b); end
    @(negedge CLK);
    ex_rs1 = 3; ex_rs2 = 4; mem_rd = 3; mem_regWrite = 1; wb_rd = 4; wb_regWrite = 1;
    #1;
    total++; if (fwd_a !== 2'b01 || fwd_b !== 2'b10) begin bad++; $display("FAIL fwd_mixed: got a=%b b=%b expected 01 10", fwd_a, fwd_b); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    @(negedge CLK);
    ex_memRead2 = 1; ex_rd = 7; id_use_rs2 = 1; id_rs2 = 7;
    #1;
    total++; if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin bad++; $display("FAIL lu_stall: got pc_write=%b if_id_write=%b expected 0 0", pc_write, if_id_write); end
    total++; if (id_ex_flush !== 1'b1 || if_id_flush !== 1'b0) begin bad++; $display("FAIL lu_flush: got id_ex=%b if_id=%b expected 1 0", id_ex_flush, if_id_flush); end
    exp_bub = 1;
    @(negedge CLK);
    ex_memRead2 = 0;
    #1;
    total++; if (pc_write !== 1'b1 || id_ex_flush !== 1'b0) begin bad++; $display("FAIL lu_release: got pc_write=%b id_ex=%b expected 1 0", pc_write, id_ex_flush); end
    total++; if (bubble_cnt !== 16'(exp_bub)) begin bad++; $display("FAIL lu_bubble: got %0d expected %0d", bubble_cnt, exp_bub); end
    @(negedge CLK);
    clear_inputs();
    ex_memRead2 = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 0;
    #1;
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL lu_unused_src: got pc_write=%b expected 1", pc_write); end
    @(negedge CLK);
    ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1;
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL lu_x0: got pc_write=%b expected 1", pc_write); end
    clear_inputs();
  endtask

  task automatic test_redirect();
    @(negedge CLK);
    ex_memRead2 = 1; ex_rd = 7; id_use_rs1 = 1; id_rs1 = 7; ex_redirect = 1;
    #1;
    total++; if (pc_write !== 1'b1 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b1) begin bad++; $display("FAIL redir_override: got pc=%b if_id=%b id_ex=%b expected 1 1 1", pc_write, if_id_flush, id_ex_flush); end
    exp_bub = 2;
    @(negedge CLK);
    clear_inputs();
    #1;
    total++; if (bubble_cnt !== 16'(exp_bub) || if_id_flush !== 1'b0) begin bad++; $display("FAIL redir_after: got bub=%0d if_id=%b expected %0d 0", bubble_cnt, if_id_flush, exp_bub); end
  endtask

  task automatic test_interrupt();
    @(negedge CLK);
    id_pc = 32'h0000_0120; intr_req = 1;
    #1;
    total++; if (pc_write !== 1'b0 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b1) begin bad++; $display("FAIL int_trigger: got pc=%b if_id=%b id_ex=%b expected 0 1 1", pc_write, if_id_flush, id_ex_flush); end
    @(negedge CLK);
    intr_req = 0; ex_redirect = 1; id_pc = 32'h0000_0999;
    #1;
    total++; if (epc !== 32'h0000_0120) begin bad++; $display("FAIL int_epc: got %h expected 00000120", epc); end
    total++; if (pc_write !== 1'b0 || if_id_write !== 1'b0 || id_ex_flush !== 1'b1 || if_id_flush !== 1'b0) begin bad++; $display("FAIL int_drain1: got pc=%b ifw=%b id_ex=%b if_id=%b expected 0 0 1 0", pc_write, if_id_write, id_ex_flush, if_id_flush); end
    @(negedge CLK);
    ex_redirect = 0;
    #1;
    total++; if (pc_write !== 1'b0 || int_take !== 1'b0) begin bad++; $display("FAIL int_drain2: got pc=%b take=%b expected 0 0", pc_write, int_take); end
    @(negedge CLK);
    #1;
    total++; if (int_take !== 1'b1 || trap_sel !== 1'b1 || pc_write !== 1'b1 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b1) begin bad++; $display("FAIL int_enter: got take=%b sel=%b pc=%b if_id=%b id_ex=%b expected 1 1 1 1 1", int_take, trap_sel, pc_write, if_id_flush, id_ex_flush); end
    exp_bub = exp_bub + 4;
    @(negedge CLK);
    #1;
    total++; if (int_take !== 1'b0 || trap_sel !== 1'b0 || pc_write !== 1'b1 || id_ex_flush !== 1'b0) begin bad++; $display("FAIL int_back_run: got take=%b sel=%b pc=%b id_ex=%b expected 0 0 1 0", int_take, trap_sel, pc_write, id_ex_flush); end
    total++; if (bubble_cnt !== 16'(exp_bub)) begin bad++; $display("FAIL int_bubble: got %0d expected %0d", bubble_cnt, exp_bub); end
    clear_inputs();
  endtask

  task automatic test_intr_redirect_and_abort();
    @(negedge CLK);
    intr_req = 1; ex_redirect = 1; id_pc = 32'h0000_0200;
    #1;
    total++; if (pc_write !== 1'b1 || if_id_flush !== 1'b1 || int_take !== 1'b0) begin bad++; $display("FAIL ir_redirect_only: got pc=%b if_id=%b take=%b expected 1 1 0", pc_write, if_id_flush, int_take); end
    @(negedge CLK);
    ex_redirect = 0; id_pc = 32'h0000_0204;
    #1;
    total++; if (pc_write !== 1'b0 || if_id_flush !== 1'b1) begin bad++; $display("FAIL ir_next_trigger: got pc=%b if_id=%b expected 0 1", pc_write, if_id_flush); end
    @(negedge CLK);
    #1;
    total++; if (epc !== 32'h0000_0204) begin bad++; $display("FAIL ir_epc: got %h expected 00000204", epc); end
    repeat (2) @(negedge CLK);
    #1;
    total++; if (int_take !== 1'b1) begin bad++; $display("FAIL ir_enter: got take=%b expected 1", int_take); end
    @(negedge CLK);
    #1;
    total++; if (pc_write !== 1'b0 || int_take !== 1'b0 || if_id_flush !== 1'b1) begin bad++; $display("FAIL ir_retrigger: got pc=%b take=%b if_id=%b expected 0 0 1", pc_write, int_take, if_id_flush); end
    @(negedge CLK);
    #1;
    total++; if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin bad++; $display("FAIL ab_drain1: got pc=%b ifw=%b expected 0 0", pc_write, if_id_write); end
    @(negedge CLK);
    RST = 1; intr_req = 0;
    #1;
    total++; if (pc_write !== 1'b1 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b1 || int_take !== 1'b0) begin bad++; $display("FAIL ab_rst_out: got pc=%b if_id=%b id_ex=%b take=%b expected 1 1 1 0", pc_write, if_id_flush, id_ex_flush, int_take); end
    @(negedge CLK);
    RST = 0;
    exp_bub = 0;
    #1;
    total++; if (epc !== 32'h0 || bubble_cnt !== 16'h0) begin bad++; $display("FAIL ab_regs: got epc=%h bub=%h expected 0 0", epc, bubble_cnt); end
    for (int i = 0; i < 4; i++) begin
      total++; if (int_take !== 1'b0 || pc_write !== 1'b1) begin bad++; $display("FAIL ab_no_take%0d: got take=%b pc=%b expected 0 1", i, int_take, pc_write); end
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic test_saturate();
    @(negedge CLK);
    ex_memRead2 = 1; ex_rd = 7; id_use_rs1 = 1; id_rs1 = 7;
    repeat (65534) @(negedge CLK);
    #1;
    total++; if (bubble_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre: got %h expected fffe", bubble_cnt); end
    repeat (6) @(negedge CLK);
    #1;
    total++; if (bubble_cnt !== 16'hFFFF || pc_write !== 1'b0) begin bad++; $display("FAIL sat_hold: got bub=%h pc=%b expected ffff 0", bubble_cnt, pc_write); end
    clear_inputs();
    @(negedge CLK);
    #1;
    total++; if (bubble_cnt !== 16'hFFFF || pc_write !== 1'b1) begin bad++; $display("FAIL sat_after: got bub=%h pc=%b expected ffff 1", bubble_cnt, pc_write); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect();
    test_interrupt();
    test_intr_redirect_and_abort();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
